riscv_fetch_fifo_param: RTL and testbench

//  Parametrised instruction prefetch buffer between the instruction-memory port and the IF stage.

---
 rtl/riscv_fetch_fifo_param.sv | 148 ++++++++++++++
 tb/tb_riscv_fetch_fifo_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_fifo_param.sv
// Instruction prefetch buffer: DEPTH 32-bit fetch words with 16/32-bit RISC-V realignment,
// zero-latency bypass when empty, occupancy/almost-full reporting and a sticky overflow flag.
module riscv_fetch_fifo_param #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter bit          RVC_EN   = 1'b1,
    parameter int unsigned AFULL_TH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic [ADDR_W-1:0]            in_addr_i,
    input  logic [31:0]                  in_rdata_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_rdata_o,
    output logic [ADDR_W-1:0]            out_addr_o,
    output logic                         out_is_compressed_o,
    output logic                         out_valid_stored_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         almost_full_o,
    output logic                         overflow_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;

    logic              empty, has_two;
    logic [ADDR_W-1:0] head_addr, word_addr, next_word, pop_addr;
    logic [31:0]       head_data, instr;
    logic [15:0]       next_lo;
    logic              unaligned, is_c, head_valid, next_valid, out_valid;
    logic              pop_en, shift_en, wr_ok, store;
    logic [OCC_W-1:0]  wr_idx;

    // Valid entries are thermometer-coded, so occupancy alone tells which entries hold data.
    assign empty   = (occ_q == '0);
    assign has_two = (occ_q >= OCC_W'(2));

    always_comb begin
        head_addr = empty ? in_addr_i : addr_q;
        if (!RVC_EN) begin
            head_addr[1] = 1'b0;
        end
    end

    assign unaligned  = head_addr[1];
    assign head_data  = empty ? in_rdata_i : mem_q[0];
    assign next_lo    = has_two ? mem_q[1][15:0] : in_rdata_i[15:0];
    assign instr      = unaligned ? {next_lo, head_data[31:16]} : head_data;
    assign is_c       = RVC_EN && (instr[1:0] != 2'b11);
    assign head_valid = !empty || in_valid_i;
    assign next_valid = has_two || (!empty && in_valid_i);
    assign out_valid  = (!unaligned || is_c) ? head_valid : next_valid;

    assign out_valid_o         = out_valid;
    assign out_rdata_o         = instr;
    assign out_addr_o          = head_addr;
    assign out_is_compressed_o = is_c;
    assign out_valid_stored_o  = (!unaligned || is_c) ? !empty : has_two;
    assign in_ready_o          = (occ_q < OCC_W'(DEPTH - 1));
    assign occupancy_o         = occ_q;
    assign almost_full_o       = afull_q;
    assign overflow_o          = ovf_q;

    // An aligned compressed pop only moves the halfword pointer; every other pop retires the head.
    assign pop_en   = out_valid && out_ready_i && !clear_i;
    assign shift_en = pop_en && !(is_c && !unaligned);
    assign wr_ok    = in_valid_i && !clear_i && ((occ_q != OCC_W'(DEPTH)) || shift_en);
    // A bypassed word that is fully consumed in its arrival cycle is never stored.
    assign store    = wr_ok && !(empty && shift_en);
    assign wr_idx   = occ_q - OCC_W'(shift_en);

    assign word_addr = {head_addr[ADDR_W-1:2], 2'b00};
    assign next_word = word_addr + ADDR_W'(4);

    always_comb begin
        if (!shift_en) begin
            pop_addr = {word_addr[ADDR_W-1:2], 2'b10};
        end else if (unaligned && !is_c) begin
            pop_addr = {next_word[ADDR_W-1:2], 2'b10};
        end else begin
            pop_addr = next_word;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (shift_en) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (store && (wr_idx == OCC_W'(i))) begin
                mem_d[i] = in_rdata_i;
            end
        end

        addr_d = addr_q;
        if (pop_en) begin
            addr_d = pop_addr;
        end else if (empty && store) begin
            addr_d = head_addr;
        end

        if (clear_i) begin
            occ_d   = '0;
            ovf_d   = 1'b0;
            afull_d = 1'b0;
        end else begin
            occ_d   = occ_q + OCC_W'(wr_ok) - OCC_W'(shift_en);
            ovf_d   = ovf_q || (in_valid_i && (occ_q == OCC_W'(DEPTH)) && !shift_en);
            afull_d = (occ_d >= OCC_W'(AFULL_TH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            occ_q   <= '0;
            addr_q  <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            occ_q   <= occ_d;
            addr_q  <= addr_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_fifo_param.sv
// Directed bench for riscv_fetch_fifo_param: vector table on an RVC_EN=1 instance plus
// hand-written sequences for asynchronous reset and an RVC_EN=0 instance.
module tb_riscv_fetch_fifo_param;

    localparam logic [31:0] D = 32'hFFFF_FFFF;
    localparam logic [31:0] H = 32'h0000_FFFF;

    typedef struct {
        logic        clr;
        logic        iv;
        logic [31:0] ia;
        logic [31:0] id;
        logic        ordy;
        logic        chk;
        logic        ov;
        logic [31:0] oa;
        logic [31:0] od;
        logic [31:0] dm;
        logic        oc;
        logic        ovs;
        logic [2:0]  occ;
        logic        irdy;
        logic        af;
        logic        of;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_addr, a_in_rdata, a_out_rdata, a_out_addr;
    logic        a_is_c, a_ovs, a_afull, a_ovf;
    logic [2:0]  a_occ;

    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_addr, b_in_rdata, b_out_rdata, b_out_addr;
    logic        b_is_c, b_ovs, b_afull, b_ovf;
    logic [2:0]  b_occ;

    int total = 0;
    int bad = 0;
    vec_t vecs[24];

    always #5 clk = ~clk;

    riscv_fetch_fifo_param #(.DEPTH(4), .ADDR_W(32), .RVC_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear_i(a_clear),
        .in_addr_i(a_in_addr), .in_rdata_i(a_in_rdata), .in_valid_i(a_in_valid),
        .in_ready_o(a_in_ready), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_rdata_o(a_out_rdata), .out_addr_o(a_out_addr), .out_is_compressed_o(a_is_c),
        .out_valid_stored_o(a_ovs), .occupancy_o(a_occ), .almost_full_o(a_afull),
        .overflow_o(a_ovf)
    );

    riscv_fetch_fifo_param #(.DEPTH(4), .ADDR_W(32), .RVC_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear_i(b_clear),
        .in_addr_i(b_in_addr), .in_rdata_i(b_in_rdata), .in_valid_i(b_in_valid),
        .in_ready_o(b_in_ready), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_rdata_o(b_out_rdata), .out_addr_o(b_out_addr), .out_is_compressed_o(b_is_c),
        .out_valid_stored_o(b_ovs), .occupancy_o(b_occ), .almost_full_o(b_afull),
        .overflow_o(b_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic iv, input logic [31:0] ia,
                                input logic [31:0] id, input logic ordy, input logic chk,
                                input logic ov, input logic [31:0] oa, input logic [31:0] od,
                                input logic [31:0] dm, input logic oc, input logic ovs,
                                input logic [2:0] occ, input logic irdy, input logic af,
                                input logic of);
        vec_t v;
        v.clr = clr; v.iv = iv; v.ia = ia; v.id = id; v.ordy = ordy; v.chk = chk;
        v.ov = ov; v.oa = oa; v.od = od; v.dm = dm; v.oc = oc; v.ovs = ovs;
        v.occ = occ; v.irdy = irdy; v.af = af; v.of = of;
        return v;
    endfunction

    initial begin
        // idle / single bypass word
        vecs[0]  = mk(0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 1, 'h100, 'h00A00093, 1,       1, 1, 'h100, 'h00A00093, D, 0,
                      0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1,                    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // two compressed instructions in one word
        vecs[3]  = mk(0, 1, 'h200, 'h00014501, 1,       1, 1, 'h200, 'h4501, H, 1,
                      0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1,                    1, 1, 'h202, 'h0001, H, 1,
                      1, 1, 1, 0, 0);
        // 32-bit instruction straddling a word boundary
        vecs[5]  = mk(0, 1, 'h200, 'h05134501, 0,       1, 1, 'h200, 'h4501, H, 1,
                      0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 1, 'h204, 'h12340001, 0,       1, 1, 'h200, 'h4501, H, 1,
                      1, 1, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1,                    1, 1, 'h200, 'h4501, H, 1,
                      1, 2, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1,                    1, 1, 'h202, 'h00010513, D, 0,
                      1, 2, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0,                    1, 1, 'h206, 'h1234, H, 1,
                      1, 1, 1, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 0,                    1, 1, 'h206, 'h1234, H, 1,
                      1, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // fill to full, then overflow
        vecs[12] = mk(0, 1, 'h400, 'h00000013, 0,       1, 1, 'h400, 'h13, D, 0,
                      0, 0, 1, 0, 0);
        vecs[13] = mk(0, 1, 'h404, 'h00100013, 0,       1, 1, 'h400, 'h13, D, 0,
                      1, 1, 1, 0, 0);
        vecs[14] = mk(0, 1, 'h408, 'h00200013, 0,       1, 1, 'h400, 'h13, D, 0,
                      1, 2, 1, 0, 0);
        vecs[15] = mk(0, 1, 'h40C, 'h00300013, 0,       1, 1, 'h400, 'h13, D, 0,
                      1, 3, 0, 1, 0);
        vecs[16] = mk(0, 1, 'h410, 'h00400013, 0,       1, 1, 'h400, 'h13, D, 0,
                      1, 4, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0,                    1, 1, 'h400, 'h13, D, 0,
                      1, 4, 0, 1, 1);
        vecs[18] = mk(0, 0, 0, 0, 1,                    1, 1, 'h400, 'h13, D, 0,
                      1, 4, 0, 1, 1);
        // clear with a concurrent input and pop
        vecs[19] = mk(1, 1, 'h500, 'hDEADBEEF, 1,       1, 1, 'h404, 'h00100013, D, 0,
                      1, 3, 0, 1, 1);
        vecs[20] = mk(0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // upper half completed by the incoming word in the same cycle
        vecs[21] = mk(0, 1, 'h600, 'h05134501, 1,       1, 1, 'h600, 'h4501, H, 1,
                      0, 0, 1, 0, 0);
        vecs[22] = mk(0, 1, 'h604, 'hABCD0001, 1,       1, 1, 'h602, 'h00010513, D, 0,
                      0, 1, 1, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0,                    1, 1, 'h606, 'hABCD, H, 1,
                      1, 1, 1, 0, 0);

        a_clear = 0; a_in_valid = 0; a_in_addr = 0; a_in_rdata = 0; a_out_ready = 0;
        b_clear = 0; b_in_valid = 0; b_in_addr = 0; b_in_rdata = 0; b_out_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a_clear     = vecs[i].clr;
            a_in_valid  = vecs[i].iv;
            a_in_addr   = vecs[i].ia;
            a_in_rdata  = vecs[i].id;
            a_out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d out_valid", i), {31'b0, a_out_valid}, {31'b0, vecs[i].ov});
            check($sformatf("v%0d valid_stored", i), {31'b0, a_ovs}, {31'b0, vecs[i].ovs});
            check($sformatf("v%0d occupancy", i), {29'b0, a_occ}, {29'b0, vecs[i].occ});
            check($sformatf("v%0d in_ready", i), {31'b0, a_in_ready}, {31'b0, vecs[i].irdy});
            check($sformatf("v%0d almost_full", i), {31'b0, a_afull}, {31'b0, vecs[i].af});
            check($sformatf("v%0d overflow", i), {31'b0, a_ovf}, {31'b0, vecs[i].of});
            if (vecs[i].chk) begin
                check($sformatf("v%0d out_addr", i), a_out_addr, vecs[i].oa);
                check($sformatf("v%0d out_rdata", i), a_out_rdata & vecs[i].dm, vecs[i].od);
                check($sformatf("v%0d is_compressed", i), {31'b0, a_is_c}, {31'b0, vecs[i].oc});
            end
        end

        // asynchronous reset while holding a word
        @(negedge clk);
        a_clear = 0; a_in_valid = 0; a_out_ready = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst occupancy", {29'b0, a_occ}, 32'd0);
        check("async_rst valid_stored", {31'b0, a_ovs}, 32'd0);
        check("async_rst out_valid", {31'b0, a_out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RVC disabled: halfword offset ignored, every pop retires a word
        @(negedge clk);
        b_in_valid = 1; b_in_addr = 'h302; b_in_rdata = 'h00004501; b_out_ready = 0;
        #1;
        check("norvc c1 out_valid", {31'b0, b_out_valid}, 32'd1);
        check("norvc c1 out_addr", b_out_addr, 'h300);
        check("norvc c1 out_rdata", b_out_rdata, 'h00004501);
        check("norvc c1 is_compressed", {31'b0, b_is_c}, 32'd0);
        @(negedge clk);
        b_in_valid = 1; b_in_addr = 'h304; b_in_rdata = 'h0000A001; b_out_ready = 1;
        #1;
        check("norvc c2 out_addr", b_out_addr, 'h300);
        check("norvc c2 occupancy", {29'b0, b_occ}, 32'd1);
        check("norvc c2 is_compressed", {31'b0, b_is_c}, 32'd0);
        @(negedge clk);
        b_in_valid = 0; b_in_addr = 0; b_in_rdata = 0; b_out_ready = 0;
        #1;
        check("norvc c3 out_addr", b_out_addr, 'h304);
        check("norvc c3 out_rdata", b_out_rdata, 'h0000A001);
        check("norvc c3 is_compressed", {31'b0, b_is_c}, 32'd0);
        check("norvc c3 occupancy", {29'b0, b_occ}, 32'd1);
        check("norvc c3 valid_stored", {31'b0, b_ovs}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
